// File: rtl/serial_operand_serializer.sv
`timescale 1ns/1ps
// Parallel-to-serial feeder for serial_adder: shifts two WIDTH-bit operands out LSB-first,
// then emits one zero flush bit so the adder's carry drains before the next word.
module serial_operand_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a,
  output logic             b,
  output logic             bit_valid,
  output logic             first,
  output logic             last,
  output logic             flush
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             xfer;
  logic             at_last;

  assign in_ready = (state != SHIFT) && !rst;
  assign xfer     = in_valid && in_ready;
  assign at_last  = (cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (xfer) next_state = SHIFT;
      SHIFT:   if (at_last) next_state = FLUSH;
      FLUSH:   next_state = xfer ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A transfer can only happen outside SHIFT, so loading takes priority over shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a <= '0;
      sh_b <= '0;
      cnt  <= '0;
    end else if (xfer) begin
      sh_a <= in_a;
      sh_b <= in_b;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      sh_a <= sh_a >> 1;
      sh_b <= sh_b >> 1;
      cnt  <= cnt + 1'b1;
    end
  end

  assign a         = (state == SHIFT) && sh_a[0];
  assign b         = (state == SHIFT) && sh_b[0];
  assign bit_valid = (state == SHIFT);
  assign first     = (state == SHIFT) && (cnt == '0);
  assign last      = (state == SHIFT) && at_last;
  assign flush     = (state == FLUSH);

endmodule

// File: tb/tb_serial_operand_serializer.sv
`timescale 1ns/1ps
// Bench for serial_operand_serializer: a cycle-schedule model predicts every output,
// a serial adder plus collector reassembles the sums, and literal sums pin the model.
module tb_serial_operand_serializer;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         a;
  logic         b;
  logic         bit_valid;
  logic         first;
  logic         last;
  logic         flush;

  int tests = 0;
  int fails = 0;

  serial_operand_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .a         (a),
    .b         (b),
    .bit_valid (bit_valid),
    .first     (first),
    .last      (last),
    .flush     (flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Downstream serial adder: combinational sum, registered carry, cleared by the shared reset.
  logic carry;
  logic sum_c;
  assign sum_c = a ^ b ^ carry;
  always @(posedge clk or posedge rst) begin
    if (rst) carry <= 1'b0;
    else     carry <= (a & b) | (a & carry) | (b & carry);
  end

  // Schedule model: cycle c is the interval after posedge c. A word transferred at posedge T
  // shows bit k in cycle T+k, its flush bit in cycle T+W, and blocks transfers in T..T+W-1.
  int           cyc = 0;
  int           t_start = -1000;
  int           xfer_count = 0;
  logic [W-1:0] wa = '0;
  logic [W-1:0] wb = '0;

  always @(posedge clk) begin
    int d;
    d = cyc - t_start;
    if (rst) begin
      t_start = -1000;
    end else if (in_valid && !(d >= 0 && d < W)) begin
      wa = in_a;
      wb = in_b;
      t_start = cyc + 1;
      xfer_count++;
    end
    cyc++;
  end

  // Packed as {in_ready, a, b, bit_valid, first, last, flush}.
  function automatic logic [6:0] model_out();
    int d;
    logic [6:0] r;
    r = '0;
    if (rst) return r;
    d = cyc - t_start;
    r[6] = !(d >= 0 && d < W);
    if (d >= 0 && d < W) begin
      r[5] = wa[d];
      r[4] = wb[d];
      r[3] = 1'b1;
      r[2] = (d == 0);
      r[1] = (d == W - 1);
    end else if (d == W) begin
      r[0] = 1'b1;
    end
    return r;
  endfunction

  logic [W-1:0] acc = '0;
  logic [W:0]   results[$];
  int           firsts[$];

  always @(negedge clk) begin
    logic [W:0] res;
    logic [W:0] exp_sum;
    check("outputs", {25'd0, in_ready, a, b, bit_valid, first, last, flush}, {25'd0, model_out()});
    if (rst) begin
      acc = '0;
    end else begin
      if (!bit_valid && !flush) check("idle_sum", {31'd0, sum_c}, 32'd0);
      if (bit_valid) acc = {sum_c, acc[W-1:1]};
      if (first) firsts.push_back(cyc);
      if (flush) begin
        res = {sum_c, acc};
        exp_sum = {1'b0, wa} + {1'b0, wb};
        results.push_back(res);
        check("word_sum", {15'd0, res}, {15'd0, exp_sum});
      end
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    int n0;
    n0 = xfer_count;
    in_a = x;
    in_b = y;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && xfer_count == n0; i++) begin
      @(posedge clk);
      #2;
    end
    check("send_accepted", xfer_count - n0, 32'd1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 200 && results.size() < n; i++) begin
      @(posedge clk);
      #2;
    end
    check("results_count", results.size(), n);
  endtask

  logic [W:0] lit[8];
  int         fidx;

  initial begin
    lit[0] = 17'h06B16;
    lit[1] = 17'h10000;
    lit[2] = 17'h00007;
    lit[3] = 17'h02345;
    lit[4] = 17'h10000;
    lit[5] = 17'h01000;
    lit[6] = 17'h0FFFF;
    lit[7] = 17'h00100;

    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_outs", {26'd0, a, b, bit_valid, first, last, flush}, 32'd0);
    check("reset_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Idle hold: the per-cycle compare covers outputs and adder sum.
    repeat (20) @(posedge clk);
    #2;

    send(16'h4DB4, 16'h1D62, 1'b0);
    wait_results(1);
    send(16'hFFFF, 16'h0001, 1'b0);
    wait_results(2);
    send(16'h0003, 16'h0004, 1'b0);
    wait_results(3);

    // Back-to-back with in_valid held; second pair changes during SHIFT and is taken at FLUSH.
    fidx = firsts.size();
    send(16'h1234, 16'h1111, 1'b1);
    send(16'h8000, 16'h8000, 1'b0);
    wait_results(5);
    if (firsts.size() >= fidx + 2) check("first_spacing", firsts[fidx+1] - firsts[fidx], 32'd17);
    else check("first_pulses", firsts.size() - fidx, 32'd2);

    // Stall: new pair offered at bit 7 must wait for FLUSH.
    send(16'h0F0F, 16'h00F1, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    check("stall_ready_low", {31'd0, in_ready}, 32'd0);
    send(16'hAAAA, 16'h5555, 1'b0);
    wait_results(7);

    // Reset asserted between edges at bit 5.
    send(16'h1357, 16'h2468, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_outs", {25'd0, in_ready, a, b, bit_valid, first, last, flush}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("ready_after_midreset", {31'd0, in_ready}, 32'd1);
    check("discarded_word", results.size(), 32'd7);
    send(16'h00FF, 16'h0001, 1'b0);
    wait_results(8);

    for (int i = 0; i < 8 && i < results.size(); i++)
      check($sformatf("literal_sum%0d", i), {15'd0, results[i]}, {15'd0, lit[i]});

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
